alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle issue/writeback sequencer directly upstream of the 8-bit ALU.
//  - Accepts one decoded instruction (op, rd, rs) from the decoder over a valid/ready handshake.
//  - Fetches operands through the register file's single read port and drives the ALU.
//  - Captures the ALU result and writes it back to R[rd], or to the branch Flag for compare ops.
//  - Only one instruction is in flight at a time.
// PARAMETERS
//  DW      8   datapath width (ALU operand/result width)
//  REG_AW  3   register-file address width (2**REG_AW registers)
// PORTS
//  Clk        in   1       clock; all state updates on rising edge
//  Reset      in   1       asynchronous, active-low reset
//  InstValid  in   1       decoder presents an instruction
//  InstReady  out  1       sequencer can accept (high only in IDLE)
//  InstOp     in   4       ALU opcode (op_mne from definitions)
//  InstRd     in   REG_AW  destination register; also source of operand A
//  InstRs     in   REG_AW  source of operand B
//  RfRdAddr   out  REG_AW  register-file read address (combinational read)
//  RfRdData   in   DW      register-file read data, same cycle as RfRdAddr
//  AluA       out  DW      ALU InputA (registered, stable from EXEC onward)
//  AluB       out  DW      ALU InputB (registered)
//  AluOp      out  4       ALU OP (registered)
//  AluOut     in   DW      ALU result (combinational from AluA/AluB/AluOp)
//  RfWrEn     out  1       register-file write strobe (one cycle)
//  RfWrAddr   out  REG_AW  write address (= captured rd)
//  RfWrData   out  DW      write data (= captured result)
//  Flag       out  1       branch flag, updated by GEQ/EQ/NEQ only
//  Done       out  1       one-cycle pulse in the WB cycle
// BEHAVIOUR
//  Reset (async, Reset==0)
//   - State goes to IDLE; all internal registers cleared.
//   - Outputs: AluA/AluB = 0, AluOp = 0, Flag = 0, RfWrEn = 0, Done = 0, RfRdAddr = 0.
//   - An in-flight instruction is abandoned with no write and no flag update.
//  States: IDLE -> READ_A -> [READ_B] -> EXEC -> WB -> IDLE
//  IDLE
//   - InstReady = 1.
//   - On InstValid&&InstReady, latch op, rd and rs; go to READ_A.
//   - Undefined ops (0100-0111, 1100, 1110, 1111) go straight to WB as a NOP.
//  READ_A
//   - RfRdAddr = rd; AluA <= RfRdData.
//   - Unary ops (LSH, RSH, NEG): AluB <= 0, go to EXEC.
//   - All other ops: go to READ_B.
//  READ_B
//   - RfRdAddr = rs; AluB <= RfRdData; go to EXEC.
//  EXEC
//   - AluOp = latched op; result <= AluOut; go to WB.
//  WB
//   - Done = 1.
//   - Compare ops (GEQ, EQ, NEQ): Flag <= result[0]; RfWrEn = 0.
//   - All other defined ops: RfWrEn = 1, RfWrAddr = rd, RfWrData = result.
//   - NOP: no write, Flag unchanged. Return to IDLE.
//  Timing
//   - Accept edge -> WB cycle is 4 cycles for binary ops and 3 for unary ops; NOP takes 1.
//   - Throughput is one instruction per 5 / 4 / 2 cycles (next accept is in the cycle after WB).
//  Other rules
//   - InstValid while InstReady = 0 is ignored; the decoder must hold it (no drop, no overwrite).
//   - rd == rs is legal: the same register is read twice.
//   - Width: all datapath values are DW bits; the ALU owns wrap-around; no carry is kept.
// STRUCTURE
//  - Package definitions: op_mne enum (LSH 0000, RSH 0001, AND 0010, OR 0011, GEQ 1000,
//    EQ 1001, NEG 1010, ADD 1011, NEQ 1101), plus an is_unary()/is_cmp()/is_valid() function set.
//  - Package definitions also holds the state enum issue_st_t {IDLE, READ_A, READ_B, EXEC, WB}.
//  - Single module; no sub-module (the FSM and operand registers are tightly coupled).
// TESTING (bench instantiates ALU plus a behavioural 8x8 reg file)
//  1. R1=3, R2=4; ADD rd=1 rs=2 -> RfWrEn in 4th cycle after accept, R1=0x07, Done=1, Flag=0.
//  2. R3=3, R4=4; GEQ rd=3 rs=4 -> Flag=0, no RfWrEn; then swap (R3=5) -> Flag=1.
//  3. R5=0x01; NEG rd=5 -> READ_B skipped, WB 3rd cycle after accept, R5=0xFF; LSH on 0x81 -> 0x02.
//  4. Op 0100 -> Done 1 cycle after accept, no RfWrEn, Flag unchanged; InstReady back next cycle.
//  5. InstValid held high for 2 back-to-back ADDs -> InstReady low during the first; second
//     accepted the cycle after WB; both results correct.
//  6. Reset asserted in EXEC of ADD R1=3+4 -> outputs zero asynchronously, R1 stays 3,
//     no Done pulse; FSM in IDLE after release.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: widths, opcodes,
// opcode classification helpers and the sequencer state encoding.
package alu_issue_ctrl_pkg;

    localparam int unsigned DW     = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        LSH = 4'b0000,
        RSH = 4'b0001,
        AND = 4'b0010,
        OR  = 4'b0011,
        GEQ = 4'b1000,
        EQ  = 4'b1001,
        NEG = 4'b1010,
        ADD = 4'b1011,
        NEQ = 4'b1101
    } op_mne_t;

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        READ_B,
        EXEC,
        WB
    } issue_st_t;

    // Single-operand ops never need the rs read
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == LSH) || (op == RSH) || (op == NEG);
    endfunction

    // Compare ops retire into the flag instead of the register file
    function automatic logic is_cmp(input logic [OP_W-1:0] op);
        return (op == GEQ) || (op == EQ) || (op == NEQ);
    endfunction

    function automatic logic is_valid(input logic [OP_W-1:0] op);
        return op inside {LSH, RSH, AND, OR, GEQ, EQ, NEG, ADD, NEQ};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of decoder handshake, register-file ports and ALU ports seen by the
// issue sequencer; master is the sequencer, slave is its surroundings.
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic              InstValid;
    logic              InstReady;
    logic [OP_W-1:0]   InstOp;
    logic [REG_AW-1:0] InstRd;
    logic [REG_AW-1:0] InstRs;
    logic [REG_AW-1:0] RfRdAddr;
    logic [DW-1:0]     RfRdData;
    logic [DW-1:0]     AluA;
    logic [DW-1:0]     AluB;
    logic [OP_W-1:0]   AluOp;
    logic [DW-1:0]     AluOut;
    logic              RfWrEn;
    logic [REG_AW-1:0] RfWrAddr;
    logic [DW-1:0]     RfWrData;
    logic              Flag;
    logic              Done;

    modport master (
        input  InstValid, InstOp, InstRd, InstRs, RfRdData, AluOut,
        output InstReady, RfRdAddr, AluA, AluB, AluOp,
               RfWrEn, RfWrAddr, RfWrData, Flag, Done
    );

    modport slave (
        output InstValid, InstOp, InstRd, InstRs, RfRdData, AluOut,
        input  InstReady, RfRdAddr, AluA, AluB, AluOp,
               RfWrEn, RfWrAddr, RfWrData, Flag, Done
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/writeback sequencer: one instruction in flight, operands
// fetched through a single RF read port, result written back or to the flag.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    alu_issue_ctrl_if.master bus
);

    issue_st_t         state;
    issue_st_t         state_d;
    logic              accept_c;
    logic [REG_AW-1:0] rd_addr_c;

    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic [DW-1:0]     result_q;
    logic [DW-1:0]     alu_a_q;
    logic [DW-1:0]     alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic              flag_q;
    logic              done_q;
    logic              wr_en_q;
    logic              ready_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and the combinational RF read address
    always_comb begin
        state_d   = state;
        accept_c  = 1'b0;
        rd_addr_c = '0;
        case (state)
            IDLE: begin
                accept_c = bus.InstValid;
                if (bus.InstValid) state_d = is_valid(bus.InstOp) ? READ_A : WB;
            end
            READ_A: begin
                rd_addr_c = rd_q;
                state_d   = is_unary(op_q) ? EXEC : READ_B;
            end
            READ_B: begin
                rd_addr_c = rs_q;
                state_d   = EXEC;
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction latch, operand/result registers and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            result_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            ready_q <= (state_d == IDLE);
            done_q  <= (state_d == WB);
            // EXEC is only reached by defined ops, so NOPs never write
            wr_en_q <= (state == EXEC) && !is_cmp(op_q);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        op_q <= bus.InstOp;
                        rd_q <= bus.InstRd;
                        rs_q <= bus.InstRs;
                    end
                end
                READ_A: begin
                    alu_a_q <= bus.RfRdData;
                    if (is_unary(op_q)) begin
                        alu_b_q  <= '0;
                        alu_op_q <= op_q;
                    end
                end
                READ_B: begin
                    alu_b_q  <= bus.RfRdData;
                    alu_op_q <= op_q;
                end
                EXEC: result_q <= bus.AluOut;
                WB: begin
                    if (is_cmp(op_q)) flag_q <= result_q[0];
                end
                default: ;
            endcase
        end
    end

    assign bus.InstReady = ready_q;
    assign bus.RfRdAddr  = rd_addr_c;
    assign bus.AluA      = alu_a_q;
    assign bus.AluB      = alu_b_q;
    assign bus.AluOp     = alu_op_q;
    assign bus.RfWrEn    = wr_en_q;
    assign bus.RfWrAddr  = rd_q;
    assign bus.RfWrData  = result_q;
    assign bus.Flag      = flag_q;
    assign bus.Done      = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU and 8x8 register file around the
// DUT, a transaction-level reference model checked every cycle, directed cases.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    alu_issue_ctrl_if bus ();
    alu_issue_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus.master));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference 8-bit ALU
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a << 1;
            4'd1:    return a >> 1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd8:    return 8'(a >= b);
            4'd9:    return 8'(a == b);
            4'd10:   return 8'(-a);
            4'd11:   return a + b;
            4'd13:   return 8'(a != b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.AluOut = alu_ref(bus.AluA, bus.AluB, bus.AluOp);

    // Behavioural register file with a bench-side preload port
    logic [7:0] rf [8];
    logic       pre_en   = 1'b0;
    logic [2:0] pre_addr = 3'd0;
    logic [7:0] pre_data = 8'd0;

    always @(posedge Clk) begin
        if (bus.RfWrEn) rf[bus.RfWrAddr] <= bus.RfWrData;
        if (pre_en)     rf[pre_addr]     <= pre_data;
    end
    assign bus.RfRdData = rf[bus.RfRdAddr];

    // Transaction-level model: cycles elapsed since accept decide every output
    logic [7:0] m_rf [8];
    bit         m_busy = 1'b0;
    bit         m_flag = 1'b0;
    bit         m_wr, m_cmp, m_nop, m_un, e_done;
    int         m_cnt, m_lat;
    logic [2:0] m_rd;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b, m_res;

    always @(negedge Clk) begin
        if (!Reset) begin
            m_busy = 1'b0;
            m_flag = 1'b0;
        end else begin
            if (pre_en) m_rf[pre_addr] = pre_data;
            if (m_busy) m_cnt++;
            e_done = m_busy && (m_cnt == m_lat);
            chk("ready", 32'(bus.InstReady), 32'(!m_busy));
            chk("done", 32'(bus.Done), 32'(e_done));
            chk("wr_en", 32'(bus.RfWrEn), 32'(e_done && m_wr));
            chk("flag", 32'(bus.Flag), 32'(m_flag));
            if (e_done && m_wr) begin
                chk("wr_addr", 32'(bus.RfWrAddr), 32'(m_rd));
                chk("wr_data", 32'(bus.RfWrData), 32'(m_res));
            end
            if (e_done && !m_nop) begin
                chk("alu_a", 32'(bus.AluA), 32'(m_a));
                chk("alu_b", 32'(bus.AluB), 32'(m_b));
                chk("alu_op", 32'(bus.AluOp), 32'(m_op));
            end
            if (e_done) begin
                if (m_wr)  m_rf[m_rd] = m_res;
                if (m_cmp) m_flag = m_res[0];
                m_busy = 1'b0;
            end else if (!m_busy && bus.InstValid) begin
                m_op  = bus.InstOp;
                m_rd  = bus.InstRd;
                m_nop = !(m_op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13});
                m_un  = m_op inside {4'd0, 4'd1, 4'd10};
                m_cmp = m_op inside {4'd8, 4'd9, 4'd13};
                m_a   = m_rf[bus.InstRd];
                m_b   = m_un ? 8'h00 : m_rf[bus.InstRs];
                m_res = alu_ref(m_a, m_b, m_op);
                m_wr  = !m_nop && !m_cmp;
                m_lat = m_nop ? 1 : (m_un ? 3 : 4);
                m_cnt = 0;
                m_busy = 1'b1;
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge Clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input bit keep, output int waited);
        logic r;
        bit   ok = 1'b0;
        bus.InstValid = 1'b1; bus.InstOp = op; bus.InstRd = rd; bus.InstRs = rs;
        waited = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            r = bus.InstReady;
            @(posedge Clk); #1;
            waited++;
            if (r) ok = 1'b1;
        end
        if (!keep) bus.InstValid = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 30 cycles");
        end
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bus.Done && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!bus.InstReady && k < 20) begin
            @(posedge Clk); #1;
            k++;
        end
        if (!bus.InstReady) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w;
        bus.InstValid = 1'b0; bus.InstOp = 4'd0; bus.InstRd = 3'd0; bus.InstRs = 3'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", 32'(bus.InstReady), 32'd1);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_wr_en", 32'(bus.RfWrEn), 32'd0);
        chk("rst_flag", 32'(bus.Flag), 32'd0);
        chk("rst_alu_a", 32'(bus.AluA), 32'd0);
        chk("rst_alu_b", 32'(bus.AluB), 32'd0);
        chk("rst_alu_op", 32'(bus.AluOp), 32'd0);
        chk("rst_rd_addr", 32'(bus.RfRdAddr), 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) set_reg(3'(i), 8'(i * 17 + 5));

        // ADD: R1 = 3 + 4
        set_reg(3'd1, 8'd3); set_reg(3'd2, 8'd4);
        send(4'b1011, 3'd1, 3'd2, 1'b0, w);
        wait_done(n);
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_wr_en", 32'(bus.RfWrEn), 32'd1);
        chk("t1_wr_data", 32'(bus.RfWrData), 32'h07);
        wait_idle();
        chk("t1_r1", 32'(rf[1]), 32'h07);
        chk("t1_flag", 32'(bus.Flag), 32'd0);

        // GEQ 3>=4 then 5>=4
        set_reg(3'd3, 8'd3); set_reg(3'd4, 8'd4);
        send(4'b1000, 3'd3, 3'd4, 1'b0, w);
        wait_done(n);
        chk("t2_wr_en", 32'(bus.RfWrEn), 32'd0);
        wait_idle();
        chk("t2_flag_lo", 32'(bus.Flag), 32'd0);
        set_reg(3'd3, 8'd5);
        send(4'b1000, 3'd3, 3'd4, 1'b0, w);
        wait_done(n);
        wait_idle();
        chk("t2_flag_hi", 32'(bus.Flag), 32'd1);
        chk("t2_r3", 32'(rf[3]), 32'd5);

        // NEG 0x01 and LSH 0x81 skip the second read
        set_reg(3'd5, 8'h01);
        send(4'b1010, 3'd5, 3'd0, 1'b0, w);
        wait_done(n);
        chk("t3_neg_latency", 32'(n), 32'd3);
        chk("t3_neg_data", 32'(bus.RfWrData), 32'hFF);
        wait_idle();
        chk("t3_r5", 32'(rf[5]), 32'hFF);
        set_reg(3'd6, 8'h81);
        send(4'b0000, 3'd6, 3'd6, 1'b0, w);
        wait_done(n);
        chk("t3_lsh_latency", 32'(n), 32'd3);
        wait_idle();
        chk("t3_r6", 32'(rf[6]), 32'h02);

        // Undefined op retires as NOP
        send(4'b0100, 3'd2, 3'd3, 1'b0, w);
        wait_done(n);
        chk("t4_latency", 32'(n), 32'd1);
        chk("t4_wr_en", 32'(bus.RfWrEn), 32'd0);
        @(posedge Clk); #1;
        chk("t4_ready", 32'(bus.InstReady), 32'd1);
        chk("t4_flag", 32'(bus.Flag), 32'd1);
        chk("t4_r2", 32'(rf[2]), 32'd4);

        // Back-to-back ADDs with InstValid held
        set_reg(3'd1, 8'd3); set_reg(3'd2, 8'd4);
        set_reg(3'd3, 8'd10); set_reg(3'd4, 8'd20);
        send(4'b1011, 3'd1, 3'd2, 1'b1, w);
        chk("t5_busy", 32'(bus.InstReady), 32'd0);
        send(4'b1011, 3'd3, 3'd4, 1'b0, w);
        chk("t5_gap", 32'(w), 32'd5);
        wait_idle();
        chk("t5_r1", 32'(rf[1]), 32'd7);
        chk("t5_r3", 32'(rf[3]), 32'd30);

        // Reset in the EXEC cycle of ADD R1 = 3 + 4
        set_reg(3'd1, 8'd3);
        send(4'b1011, 3'd1, 3'd2, 1'b0, w);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        chk("t6_alu_a", 32'(bus.AluA), 32'd0);
        chk("t6_alu_b", 32'(bus.AluB), 32'd0);
        chk("t6_alu_op", 32'(bus.AluOp), 32'd0);
        chk("t6_flag", 32'(bus.Flag), 32'd0);
        chk("t6_done", 32'(bus.Done), 32'd0);
        chk("t6_wr_en", 32'(bus.RfWrEn), 32'd0);
        chk("t6_rd_addr", 32'(bus.RfRdAddr), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        chk("t6_ready", 32'(bus.InstReady), 32'd1);
        repeat (3) begin
            @(posedge Clk); #1;
            chk("t6_no_done", 32'(bus.Done), 32'd0);
        end
        chk("t6_r1", 32'(rf[1]), 32'd3);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.InstValid = 1'b0;
                wait_idle();
                set_reg(3'($urandom_range(0, 7)), 8'($urandom));
            end
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), w);
            if (!bus.InstValid) repeat ($urandom_range(0, 2)) begin
                @(posedge Clk); #1;
            end
        end
        bus.InstValid = 1'b0;
        wait_idle();
        @(posedge Clk); #1;
        for (int i = 0; i < 8; i++) chk("final_rf", 32'(rf[i]), 32'(m_rf[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
